// File: rtl/ibuf_feed.sv
// Purpose: per-lane operand buffers written over the RAM bus, streamed into the systolic array with a diagonal skew.
// Latency: lane k presents entry i in cycle 2+i+k after cmd_start is sampled (1-cycle RAM read plus k skew stages).
// Backpressure: none; the stream is free-running, and only cmd_abort or the downstream finish pulse ends a run.
module ibuf_feed #(
   parameter int LANES = 4,
   parameter int DW    = 16,
   parameter int AW    = 8,
   localparam int LW   = (LANES > 1) ? $clog2(LANES) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [AW+LW-1:0]    ibus_wadr,
   input  logic [DW-1:0]       ibus_wdata,
   input  logic                ibus_wen,
   input  logic                cmd_start,
   input  logic [AW-1:0]       cmd_len,
   input  logic                cmd_abort,
   output logic                busy,
   output logic                done,
   output logic [LANES*DW-1:0] a_data,
   output logic [LANES-1:0]    a_valid,
   output logic [AW-1:0]       run_cntr,
   output logic                start,
   input  logic                finish
);

   typedef enum logic [1:0] {IDLE, FEED, DRAIN, WAIT_FIN} state_t;

   state_t        state, state_nxt;
   logic [AW-1:0] len;
   logic [AW-1:0] rd_ptr;
   logic [LW-1:0] drn_cnt;
   logic          rd_en;
   logic          rd_vld;
   logic          accept;
   logic          done_nxt;
   logic          flush;
   logic          wr_en;
   logic [LW-1:0] wr_lane;
   logic [AW-1:0] wr_ent;

   assign busy    = (state != IDLE);
   assign flush   = cmd_abort && (state != IDLE);
   assign wr_en   = ibus_wen && (state == IDLE);
   assign wr_lane = ibus_wadr[AW +: LW];
   assign wr_ent  = ibus_wadr[AW-1:0];

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state and control decode; abort overrides everything, including a same-cycle start
   always_comb begin
      state_nxt = state;
      rd_en     = 1'b0;
      accept    = 1'b0;
      done_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (cmd_start && (cmd_len != '0) && !cmd_abort) begin
               state_nxt = FEED;
               accept    = 1'b1;
            end
         end
         FEED: begin
            rd_en = 1'b1;
            if (rd_ptr == len - AW'(1)) state_nxt = DRAIN;
         end
         DRAIN: begin
            if (drn_cnt == LW'(LANES-1)) state_nxt = WAIT_FIN;
         end
         WAIT_FIN: begin
            if (finish) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (flush) begin
         state_nxt = IDLE;
         rd_en     = 1'b0;
         done_nxt  = 1'b0;
      end
   end

   // Run bookkeeping: length latch, read pointer, drain counter, start/done pulses, downstream count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         len      <= '0;
         rd_ptr   <= '0;
         drn_cnt  <= '0;
         start    <= 1'b0;
         done     <= 1'b0;
         run_cntr <= '0;
         rd_vld   <= 1'b0;
      end else begin
         start  <= accept;
         done   <= done_nxt;
         rd_vld <= rd_en;
         if (accept) begin
            len      <= cmd_len;
            rd_ptr   <= '0;
            run_cntr <= cmd_len;
         end else if (rd_en) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         if (state == DRAIN) drn_cnt <= drn_cnt + LW'(1);
         else                drn_cnt <= '0;
      end
   end

   genvar k;
   for (k = 0; k < LANES; k++) begin : g_lane
      logic [DW-1:0] mem [2**AW];
      logic [DW-1:0] rdata;
      logic [DW-1:0] lane_dat;
      logic          lane_vld;

      // Buffer storage: one write port from the bus, one synchronous read port for the stream
      always_ff @(posedge clk) begin
         if (wr_en && (wr_lane == LW'(k))) mem[wr_ent] <= ibus_wdata;
         if (rd_en) rdata <= mem[rd_ptr];
      end

      if (k == 0) begin : g_noskew
         assign lane_dat = rdata;
         assign lane_vld = rd_vld;
      end else begin : g_skew
         logic [DW-1:0] pd [k];
         logic [k-1:0]  pv;
         // Skew pipe of k stages; abort empties it so no stale words leak out
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               pv <= '0;
               for (int j = 0; j < k; j++) pd[j] <= '0;
            end else if (flush) begin
               pv <= '0;
            end else begin
               pd[0] <= rdata;
               pv[0] <= rd_vld;
               for (int j = 1; j < k; j++) begin
                  pd[j] <= pd[j-1];
                  pv[j] <= pv[j-1];
               end
            end
         end
         assign lane_dat = pd[k-1];
         assign lane_vld = pv[k-1];
      end

      // Data is forced to zero whenever the lane is not valid
      assign a_data[k*DW +: DW] = lane_vld ? lane_dat : '0;
      assign a_valid[k]         = lane_vld;
   end

endmodule

// File: doc/ibuf_feed.md
# ibuf_feed

Input-side sequencer for the systolic array. It holds the operand vectors written over the RAM bus in per-lane buffers. On a start command it streams them into the array with a diagonal skew, so lane k lags lane 0 by k cycles. It also issues `start`/`run_cntr` to the downstream output buffer and ends the run when that buffer reports `finish`.

## Interface
- LANES, 4, number of array input lanes (row inputs)
- DW, 16, data width per lane
- AW, 8, buffer depth is 2**AW entries per lane
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- ibus_wadr  input  AW+log2(LANES)  write address; upper bits = lane, lower AW bits = entry
- ibus_wdata  input  DW  write data
- ibus_wen  input  1  write strobe
- cmd_start  input  1  run request pulse
- cmd_len  input  AW  vectors to stream, sampled with cmd_start
- cmd_abort  input  1  abort current run
- busy  output  1  high from accepted start until IDLE
- done  output  1  one-cycle pulse when a run completes normally
- a_data  output  LANES*DW  lane k at bits [k*DW +: DW]
- a_valid  output  LANES  per-lane valid, skewed
- run_cntr  output  AW  output count for downstream buffer
- start  output  1  one-cycle pulse to downstream buffer
- finish  input  1  downstream buffer run-complete pulse

## Operation
- Buffers: LANES x 2**AW x DW, 1 write/1 read port, synchronous read with 1-cycle latency. Contents are not reset.
- Writes with ibus_wen=1 land when busy=0. Writes while busy=1 are dropped.
- FSM states: IDLE, FEED, DRAIN, WAIT_FIN.
- IDLE: cmd_start=1 and cmd_len!=0 → FEED. Latch len, clear rd_ptr, pulse `start`, drive run_cntr=cmd_len. cmd_start with cmd_len=0 is ignored: no start, no done.
- FEED: all lanes read entry rd_ptr each cycle and rd_ptr increments. When rd_ptr==len-1 the read is issued → DRAIN.
- DRAIN: count LANES cycles so the last skewed lane word leaves → WAIT_FIN.
- WAIT_FIN: finish=1 → IDLE with done=1 for that cycle.
- Skew: lane k read data passes through k pipeline registers (data and valid). Lane 0 has none.
- cmd_start while busy is ignored. finish outside WAIT_FIN is ignored.
- cmd_abort in any non-IDLE state → IDLE next cycle.
  - Skew pipes and a_valid clear; no done.
  - start is not re-issued. run_cntr holds its last value.
- rd_ptr does not wrap within a run, since len ≤ 2**AW-1.

## Timing
- Reset values: busy=0, done=0, start=0, a_valid=0, a_data=0, run_cntr=0. FSM=IDLE.
- cmd_start sampled at edge 0. In cycle 1: state FEED, start=1, busy=1, run_cntr=len, entry 0 read issued.
- Lane k presents entry i in cycle 2+i+k with a_valid[k]=1. It is 0 otherwise, and a_data for that lane holds 0 when invalid.
- Last valid: lane LANES-1 in cycle 1+len+LANES-1. DRAIN ends so WAIT_FIN is entered in cycle 2+len+LANES-1.
- done asserts the cycle after finish is sampled in WAIT_FIN. busy drops in that same cycle.
- Earliest next cmd_start is accepted the cycle done=1 is visible.
- cmd_abort and cmd_start in the same cycle: abort wins, IDLE.
- ibus_wen and accepted cmd_start in the same cycle: the write lands, busy rises next cycle.
- Async reset mid-run: outputs go to reset values immediately. No done, no extra start.

## Test plan
- Write lane k entry i = {k[7:0], i[7:0]} for i<8. Start len=8 → start pulse cycle 1, run_cntr=8; lane2 outputs 0x0200..0x0207 in cycles 4..11, a_valid[2] only then.
- Same setup, drive finish 5 cycles after WAIT_FIN entry → done one cycle after finish, busy low. Second start len=3 accepted immediately.
- cmd_len=0 start → no start pulse, busy stays 0. Write during busy to lane0/entry0 → entry unchanged in the next run.
- cmd_abort in FEED at rd_ptr=3 (len=10) → a_valid=0 next cycle, busy=0, no done. A later finish pulse is ignored.
- len=255 with buffer pattern → entry 254 on lane 3 in cycle 259. No wrap to entry 0.
- rst_n low mid-DRAIN → all outputs 0 asynchronously. After release, a new run streams the retained buffer data correctly.
